// File: rtl/vc_arb_pkg.sv
// Shared types and the round-robin search helper for the credit-gated link arbiter.
package vc_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int RR_MAX_REQ = 32;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } rr_pick_t;

   // First set bit of valid, scanning ptr, ptr+1, ... modulo num (num <= RR_MAX_REQ).
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                        input int unsigned ptr,
                                        input int unsigned num);
      rr_pick_t    r;
      int unsigned j;
      r = '0;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         j = ptr + k;
         if (j >= num) j = j - num;
         if (!r.found && (k < num) && valid[j[4:0]]) begin
            r.found = 1'b1;
            r.idx   = j[4:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vc_link_arbiter_rr_picker.sv
// Combinational rotate/priority-encode of N request valids starting at ptr.
module rr_picker
   import vc_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_pick(RR_MAX_REQ'(valid), 32'(ptr), N);
      found = pick.found;
      idx   = W'(pick.idx);
   end

endmodule

// File: rtl/vc_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered valid/credit link
// among NUM_REQ ready/valid requesters; issue is gated by a receiver credit count.
module vc_link_arbiter
   import vc_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CREDITS    = 7,
   localparam int CTR_W     = $clog2(CREDITS + 1),
   localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            in_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]            in_last,
   output logic [NUM_REQ-1:0]            in_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [SRC_W-1:0]              out_src,
   input  logic                          credit_in,
   output logic [CTR_W-1:0]              credit_cnt,
   output logic                          credit_overflow,
   output logic                          dbg_state
);

   localparam logic [CTR_W-1:0] CREDIT_MAX = CTR_W'(CREDITS);
   localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(NUM_REQ - 1);

   arb_state_t            state, state_next;
   logic [SRC_W-1:0]      lock_src, rr_ptr, grant, pick_idx;
   logic                  pick_found, grant_valid, grant_last, fire;
   logic [DATA_WIDTH-1:0] grant_data;

   rr_picker #(.N(NUM_REQ), .W(SRC_W)) u_picker (
      .valid (in_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Handshake: a beat transfers on a cycle where in_valid[i] and in_ready[i]
   // are both high; in_ready depends only on registered state and in_valid,
   // never on credit_in, so a returned credit is spendable one cycle later.
   always_comb begin
      grant       = (state == ARB_LOCKED) ? lock_src : pick_idx;
      grant_valid = (state == ARB_LOCKED) ? in_valid[lock_src] : pick_found;
      fire        = grant_valid && (credit_cnt != '0);
      grant_data  = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      grant_last  = in_last[grant];
      in_ready    = '0;
      if (fire) in_ready[grant] = 1'b1;
   end

   always_comb begin
      state_next = state;
      if (fire) state_next = grant_last ? ARB_IDLE : ARB_LOCKED;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ARB_IDLE;
         lock_src        <= '0;
         rr_ptr          <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_last        <= 1'b0;
         out_src         <= '0;
         credit_cnt      <= CREDIT_MAX;
         credit_overflow <= 1'b0;
      end else begin
         state     <= state_next;
         out_valid <= fire;
         if (fire && !grant_last) lock_src <= grant;
         // Pointer only advances at packet end, so a stalled packet keeps priority.
         if (fire && grant_last) rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
         if (fire) begin
            out_data <= grant_data;
            out_last <= grant_last;
            out_src  <= grant;
         end
         case ({fire, credit_in})
            2'b10:   credit_cnt <= credit_cnt - 1'b1;
            2'b01: begin
               if (credit_cnt == CREDIT_MAX) credit_overflow <= 1'b1;
               else                          credit_cnt      <= credit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Directed bench for vc_link_arbiter: a vector table for steady arbitration and
// credit behaviour, plus hand sequences for packet locking and asynchronous reset.
module tb_vc_link_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_last = '0;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_src;
   logic        credit_in = 1'b0;
   logic [2:0]  credit_cnt;
   logic        credit_overflow;
   logic        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   vc_link_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .CREDITS(7)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_last         (in_last),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_last        (out_last),
      .out_src         (out_src),
      .credit_in       (credit_in),
      .credit_cnt      (credit_cnt),
      .credit_overflow (credit_overflow),
      .dbg_state       (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] valid;
      logic       credit;
      logic [3:0] exp_ready;
      logic       exp_ov;
      logic [1:0] exp_src;
      logic [2:0] exp_cnt;
      logic       exp_ovf;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_default_data();
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
   endtask

   task automatic do_reset(input string tag);
      reset_n   = 1'b0;
      in_valid  = '0;
      in_last   = '0;
      credit_in = 1'b0;
      set_default_data();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      chk({tag, " rst out_valid"}, 32'(out_valid), 0);
      chk({tag, " rst out_data"}, 32'(out_data), 0);
      chk({tag, " rst out_last"}, 32'(out_last), 0);
      chk({tag, " rst out_src"}, 32'(out_src), 0);
      chk({tag, " rst credit_cnt"}, 32'(credit_cnt), 7);
      chk({tag, " rst overflow"}, 32'(credit_overflow), 0);
      chk({tag, " rst state"}, 32'(dbg_state), 0);
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle: check in_ready before the edge, registered outputs after it.
   task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                       input logic c, input logic [3:0] e_rdy, input logic e_ov,
                       input logic [1:0] e_src, input logic e_last, input logic [7:0] e_data,
                       input logic [2:0] e_cnt, input logic e_state);
      in_valid  = v;
      in_last   = l;
      credit_in = c;
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
      chk({tag, " out_src"}, 32'(out_src), 32'(e_src));
      chk({tag, " out_last"}, 32'(out_last), 32'(e_last));
      chk({tag, " out_data"}, 32'(out_data), 32'(e_data));
      chk({tag, " credit_cnt"}, 32'(credit_cnt), 32'(e_cnt));
      chk({tag, " state"}, 32'(dbg_state), 32'(e_state));
   endtask

   initial begin
      // Tests 1, 2 and 5: single-beat packets from all requesters.
      vq.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 3'd6, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd5, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 3'd4, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 3'd3, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 3'd2, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd1, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 3'd0, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd2, 3'd0, 1'b0});
      vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 3'd1, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 3'd0, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0000, 1'b0, 2'd3, 3'd0, 1'b0});
      vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 3'd1, 1'b0});
      vq.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 3'd0, 1'b0});
      for (int i = 1; i <= 7; i++)
         vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 3'(i), 1'b0});
      vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 3'd7, 1'b1});
      vq.push_back('{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 3'd6, 1'b1});
      vq.push_back('{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 3'd5, 1'b1});
      vq.push_back('{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 3'd4, 1'b1});
      vq.push_back('{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 3'd3, 1'b1});
      vq.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 3'd3, 1'b1});
      vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 3'd4, 1'b1});

      do_reset("t1");
      for (int i = 0; i < vq.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         step(tag, vq[i].valid, 4'b1111, vq[i].credit, vq[i].exp_ready, vq[i].exp_ov,
              vq[i].exp_src, 1'b1, 8'hA0 + 8'(vq[i].exp_src), vq[i].exp_cnt, 1'b0);
         chk({tag, " overflow"}, 32'(credit_overflow), 32'(vq[i].exp_ovf));
      end

      // Test 3: req1 three-beat packet while req0/req2 stay valid.
      do_reset("t3");
      step("t3 pre", 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'hA0, 3'd6, 1'b0);
      in_data[15:8] = 8'h11;
      step("t3 b1", 4'b0111, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h11, 3'd5, 1'b1);
      in_data[15:8] = 8'h12;
      step("t3 b2", 4'b0111, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h12, 3'd4, 1'b1);
      in_data[15:8] = 8'h13;
      step("t3 b3", 4'b0111, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'h13, 3'd3, 1'b0);
      set_default_data();
      step("t3 next", 4'b0101, 4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA2, 3'd2, 1'b0);

      // Test 4: locked source stalls for four cycles, then resumes.
      do_reset("t4");
      step("t4 b1", 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 8'hA1, 3'd6, 1'b1);
      for (int i = 0; i < 4; i++)
         step($sformatf("t4 stall%0d", i), 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0,
              2'd1, 1'b0, 8'hA1, 3'd6, 1'b1);
      step("t4 b2", 4'b0111, 4'b0111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA1, 3'd5, 1'b0);
      step("t4 next", 4'b0101, 4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA2, 3'd4, 1'b0);

      // Test 6: asynchronous reset in the middle of a req3 packet.
      do_reset("t6");
      step("t6 a", 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA2, 3'd6, 1'b0);
      step("t6 b", 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 8'hA3, 3'd5, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6 async out_valid", 32'(out_valid), 0);
      chk("t6 async credit_cnt", 32'(credit_cnt), 7);
      chk("t6 async state", 32'(dbg_state), 0);
      chk("t6 async out_src", 32'(out_src), 0);
      in_valid = '0;
      in_last  = '0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      step("t6 restart", 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'hA0, 3'd6, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
